// File: rtl/anfsqrt_sqrchk_pkg.sv
// Shared definitions for the squaring / root-check unit.
//   state_t : FSM state encoding (IDLE, MUL, CHK, DONE), 2 bits.
//   DEF_W   : default root width in bits.
package anfsqrt_sqrchk_pkg;

    localparam int DEF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_CHK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/anfsqrt_sqrchk_step.sv
// One step of a bit-serial shift-add multiplier. Purely combinational.
// It adds the multiplicand into the accumulator when the current
// multiplier LSB is set. It then shifts the multiplicand left and the
// multiplier right.
// Ports:
//   i_acc / o_acc     : 2W-bit partial product in / out
//   i_mcand / o_mcand : 2W-bit shifted multiplicand in / out
//   i_mult / o_mult   : W-bit remaining multiplier bits in / out
module anfsqrt_sqr_step #(
    parameter int W = 16
) (
    input  logic [2*W-1:0] i_acc,
    input  logic [2*W-1:0] i_mcand,
    input  logic [W-1:0]   i_mult,
    output logic [2*W-1:0] o_acc,
    output logic [2*W-1:0] o_mcand,
    output logic [W-1:0]   o_mult
);

    // The accumulator never exceeds (2^W-1)^2, so this add cannot overflow.
    assign o_acc   = i_mult[0] ? (i_acc + i_mcand) : i_acc;
    assign o_mcand = i_mcand << 1;
    assign o_mult  = i_mult >> 1;

endmodule

// File: rtl/anfsqrt_sqrchk.sv
// Iterative squaring and root-check unit.
// A request carries a candidate root r and a radicand n. The unit squares r
// over W fixed cycles. It then reports r*r and whether r == floor(sqrt(n)).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : request handshake
//   in_root  [W-1:0]     : candidate root r
//   in_rad   [2W-1:0]    : radicand n
//   out_valid / out_ready: result handshake
//   out_sq   [2W-1:0]    : r*r
//   out_ok               : 1 iff r*r <= n < (r+1)^2
module anfsqrt_sqrchk
    import anfsqrt_sqrchk_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_root,
    input  logic [2*W-1:0] in_rad,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_sq,
    output logic           out_ok
);

    localparam int CW = $clog2(W) + 1;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_root;
    logic [2*W-1:0] r_rad;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mult;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_sq;
    logic           r_ok;

    logic [2*W-1:0] w_acc_next;
    logic [2*W-1:0] w_mcand_next;
    logic [W-1:0]   w_mult_next;
    logic [2*W:0]   w_hi;
    logic           w_ok;
    logic           w_accept;
    logic           w_last_step;

    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_last_step = (r_cnt == CW'(W - 1));

    anfsqrt_sqr_step #(.W(W)) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_mult  (r_mult),
        .o_acc   (w_acc_next),
        .o_mcand (w_mcand_next),
        .o_mult  (w_mult_next)
    );

    // (r+1)^2 = r^2 + 2r + 1. This reaches 2^(2W) when r is all ones,
    // so it takes one extra bit.
    assign w_hi = {1'b0, r_acc} + {{W{1'b0}}, r_root, 1'b0} + (2*W+1)'(1);
    assign w_ok = (r_acc <= r_rad) && ({1'b0, r_rad} < w_hi);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. The multiply has a fixed W-cycle latency.
    // It does not exit early when the multiplier runs out of set bits.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_next = ST_MUL;
            ST_MUL:  if (w_last_step) w_state_next = ST_CHK;
            ST_CHK:                   w_state_next = ST_DONE;
            ST_DONE: if (out_ready)   w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    // Output decode. All outputs read as zero while reset is held, even
    // before the first reset edge has cleared the registers.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sq    = '0;
        out_ok    = 1'b0;
        if (rst_n) begin
            in_ready  = (r_state == ST_IDLE);
            out_valid = (r_state == ST_DONE);
            out_sq    = r_sq;
            out_ok    = r_ok;
        end
    end

    // Operand and multiplier datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_root  <= '0;
            r_rad   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mult  <= '0;
            r_cnt   <= '0;
            r_sq    <= '0;
            r_ok    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_root  <= in_root;
                        r_rad   <= in_rad;
                        r_acc   <= '0;
                        r_mcand <= {{W{1'b0}}, in_root};
                        r_mult  <= in_root;
                        r_cnt   <= '0;
                    end
                end
                ST_MUL: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= w_mcand_next;
                    r_mult  <= w_mult_next;
                    r_cnt   <= r_cnt + CW'(1);
                end
                ST_CHK: begin
                    r_sq <= r_acc;
                    r_ok <= w_ok;
                end
                default: ;
            endcase
        end
    end

endmodule
